// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port; registers the
// winning write and its 4:16 decoded enable. Optional: REGFILE_WR_ZERO_REG_EN.
module regfile_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]  req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic                     wr_stall_i,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [DATA_W-1:0]        wr_data_o,
    output logic [15:0]              wr_onehot_o,
    output logic [2:0]               grant_id_o
);

    localparam logic [2:0] LAST = 3'(N_REQ - 1);

    logic [N_REQ-1:0][ADDR_W-1:0] addr_arr;
    logic [N_REQ-1:0][DATA_W-1:0] data_arr;
    logic [2:0]                   ptr;
    logic [2:0]                   win;
    logic                         found;
    logic                         go;
    logic [ADDR_W-1:0]            win_addr;
    logic [DATA_W-1:0]            win_data;
    logic [15:0]                  win_dec;
    logic                         zero_hit;

    assign addr_arr = req_addr_i;
    assign data_arr = req_data_i;

    // Two passes: requesters at or above ptr first, then the wrapped-around rest.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && (3'(k) >= ptr) && req_valid_i[k]) begin
                found = 1'b1;
                win   = 3'(k);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid_i[k]) begin
                found = 1'b1;
                win   = 3'(k);
            end
        end
    end

    assign go = found && rst_ni && !wr_stall_i;

    always_comb begin
        req_ready_o = '0;
        win_addr    = '0;
        win_data    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready_o[k] = go && (win == 3'(k));
            if (win == 3'(k)) begin
                win_addr = addr_arr[k];
                win_data = data_arr[k];
            end
        end
    end

    assign win_dec = 16'h0001 << win_addr;

`ifdef REGFILE_WR_ZERO_REG_EN
    // 4'hF reads as zero: the request is consumed but never reaches the file.
    assign zero_hit = (win_addr == 4'hF);
`else
    assign zero_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr         <= '0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            wr_onehot_o <= '0;
            grant_id_o  <= '0;
        end else if (!wr_stall_i) begin
            if (go) begin
                ptr         <= (win == LAST) ? 3'd0 : win + 3'd1;
                wr_en_o     <= !zero_hit;
                wr_addr_o   <= win_addr;
                wr_data_o   <= win_data;
                wr_onehot_o <= zero_hit ? 16'h0000 : win_dec;
                grant_id_o  <= win;
            end else begin
                wr_en_o     <= 1'b0;
                wr_onehot_o <= '0;
            end
        end
    end

endmodule
